irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt request front end that sits directly upstream of the pipelined CPU's interrupt inputs.
- Takes raw asynchronous board-level requests (buttons/switches) and synchronizes them.
- Converts rising edges into sticky pending bits and arbitrates by fixed priority with nesting.
- Presents a single request, ID and vector to the CPU. Handles the CPU's acknowledge/return handshake and drives per-line waiting indicators (LEDs).

Parameters:
- N_IRQ, 3, number of interrupt lines; line N_IRQ-1 has the highest priority.
- ID_W, 2, width of irq_id; must satisfy 2^ID_W >= N_IRQ+1 (ID 0 reserved = none).
- ADDR_WIDTH, 16, width of the vector address.
- VEC_BASE, 16'h0100, handler address for line 0.
- VEC_STRIDE, 16'h0040, address spacing between handlers.
- DEBOUNCE_CYCLES, 16, stable-cycle count; used only with the optional feature.

Ports:
- clk  in  1  CPU clock; single clock domain for the block.
- rst  in  1  asynchronous, active-low reset.
- irq_raw  in  N_IRQ  raw, unsynchronized requests; a rising edge means a request.
- int_en  in  1  CPU global interrupt enable.
- int_ack  in  1  one-cycle pulse; CPU has taken the currently presented interrupt.
- eret  in  1  one-cycle pulse; CPU has finished the current handler.
- irq_req  out  1  registered interrupt request to the CPU.
- irq_id  out  ID_W  registered; line index + 1 of the presented request, 0 when none.
- irq_vec  out  ADDR_WIDTH  registered; VEC_BASE + (irq_id-1)*VEC_STRIDE, 0 when none.
- irw  out  N_IRQ  pending (waiting) bits, for LEDs.
- in_service  out  N_IRQ  lines whose handlers are active (nested stack as a mask).

Behaviour:
- Reset (rst=0, asynchronous): synchronizers, pending, in_service, irq_req, irq_id and irq_vec all go to 0. Deasserting reset is registered on the next edge.
- Input path per line: 2-flop synchronizer, then a previous-value flop. edge[i] = sync[i] & ~prev[i].
- Latency:
  - Edge k is the first rising edge that samples irq_raw[i]=1.
  - pending[i] sets at edge k+2.
  - irq_req/irq_id/irq_vec are valid after edge k+3.
- pending[i]:
  - set on edge[i]; cleared on an accepted int_ack when irq_id==i+1.
  - A new edge in the same cycle as its clearing ack wins: pending stays 1.
  - Repeated edges while pending are merged; no count is kept.
- Current level L = index of the highest set in_service bit + 1, or 0 if none.
- Candidate = highest-index set pending bit whose index+1 > L.
- Next-state registration:
  - irq_req <= int_en & candidate exists.
  - irq_id <= candidate+1, else 0.
  - irq_vec is updated from irq_id accordingly.
- int_ack accepted only when irq_req=1 in that cycle; otherwise ignored with no state change.
- On an accepted ack: pending[irq_id-1] <= 0 and in_service[irq_id-1] <= 1. irq_req deasserts after that edge unless another higher candidate exists.
- eret clears the highest set in_service bit. eret with in_service=0 is a no-op.
- eret and int_ack in the same cycle: eret's clear is applied first, then the ack's set. Both take effect at the same edge.
- int_en=0 masks irq_req only; pending bits continue to accumulate and irw still shows them.
- Lower-priority requests wait until eret lowers L. Equal or lower priority never preempts.
- irw = pending (registered). in_service is driven directly from its register.

Optional Feature:
- Macro: IRQ_DEBOUNCE_EN.
- Defined: per-line counter after the synchronizer. The filtered level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter. Edge detection uses the filtered level. Latency grows by DEBOUNCE_CYCLES.
- Undefined: no counters; behaviour and latency exactly as above. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package irq_pkg holds:
  - N_IRQ and ID_W defaults;
  - the ID_NONE=0 constant;
  - a highest-set-bit priority-encode function shared by the candidate and level logic.
- Sub-module irq_sync_edge, instantiated N_IRQ times: synchronizer, optional debounce, previous-value flop and edge output.
- Pending, in_service and the output registers stay in irq_controller.

Test Plan:
- Reset mid-request: pulse irq_raw[1] and assert rst=0 at edge k+2 → all outputs 0. No irq_req after release until a new edge arrives.
- Single request: int_en=1, irq_raw[0] rises → irq_req=1, irq_id=1, irq_vec=16'h0100 after edge k+3. int_ack → irw=000, in_service=001, irq_req=0. eret → in_service=000.
- Priority/simultaneous: irq_raw[0] and [2] rise together → irq_id=3, irq_vec=16'h0180. After ack, irq_id stays 0 (line 0 is lower than L=3). After eret → irq_id=1.
- Nesting: line 0 in service, irq_raw[1] rises → irq_req=1, irq_id=2. Ack → in_service=011. First eret → in_service=001. Second eret → 000.
- Masking and ignored ack: int_en=0 with irq_raw[2] edge → irw=100, irq_req=0. int_ack pulse → no change. int_en=1 → irq_req=1 the next edge.
- IRQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle glitch on irq_raw[0] → no pending. Stable 6-cycle high → pending set DEBOUNCE_CYCLES cycles later than the baseline latency.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types, defaults and helpers for the interrupt controller.
// hsb_id() returns highest set bit index + 1, or 0 when the vector is empty.
package irq_pkg;

  localparam int DEF_N_IRQ = 3;
  localparam int DEF_ID_W  = 2;
  localparam int ID_NONE   = 0;
  localparam int MAX_IRQ   = 32;

  function automatic logic [5:0] hsb_id(
    input logic [MAX_IRQ-1:0] v
  );
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (v[i]) r = 6'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line 2-flop synchronizer, optional debounce (IRQ_DEBOUNCE_EN), edge detect.
// Ports: clk, rst (async active-low), raw_i (async level), edge_o (1-cycle rise).
module irq_sync_edge
  import irq_pkg::*;
#(
`ifdef IRQ_DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic edge_o
);

  logic s1_q, s2_q, prev_q, lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

`ifdef IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Filtered level follows s2 only after a full run of
  // consecutive differing cycles; any bounce restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (s2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= lvl;
  end

  assign edge_o = lvl & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt front end: sync/edge, sticky pending, nested fixed-priority arbitration.
// Ports: clk, rst(async low), irq_raw, int_en, int_ack, eret -> irq_req, irq_id, irq_vec, irw, in_service. Option: IRQ_DEBOUNCE_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int                    N_IRQ      = DEF_N_IRQ,
  parameter int                    ID_W       = DEF_ID_W,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] VEC_STRIDE = 16'h0040
`ifdef IRQ_DEBOUNCE_EN
  ,
  parameter int                    DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IRQ-1:0]      irq_raw,
  input  logic                  int_en,
  input  logic                  int_ack,
  input  logic                  eret,
  output logic                  irq_req,
  output logic [ID_W-1:0]       irq_id,
  output logic [ADDR_WIDTH-1:0] irq_vec,
  output logic [N_IRQ-1:0]      irw,
  output logic [N_IRQ-1:0]      in_service
);

  logic [N_IRQ-1:0] edge_w;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
`ifdef IRQ_DEBOUNCE_EN
    irq_sync_edge #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_se (
      .clk   (clk),
      .rst   (rst),
      .raw_i (irq_raw[g]),
      .edge_o(edge_w[g])
    );
`else
    irq_sync_edge u_se (
      .clk   (clk),
      .rst   (rst),
      .raw_i (irq_raw[g]),
      .edge_o(edge_w[g])
    );
`endif
  end

  logic [N_IRQ-1:0]      pend_q, pend_d;
  logic [N_IRQ-1:0]      isv_q, isv_d;
  logic [N_IRQ-1:0]      ack_clr, isv_clr, pend_eff;
  logic                  req_q, req_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ADDR_WIDTH-1:0] vec_q, vec_d;
  logic [ID_W-1:0]       lvl, lvl_n, pid;
  logic                  ack_ok, has;

  always_comb begin
    ack_ok  = int_ack & req_q;
    lvl     = ID_W'(hsb_id(MAX_IRQ'(isv_q)));
    ack_clr = '0;
    isv_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = ack_ok & (id_q == ID_W'(i + 1));
      isv_clr[i] = eret & (lvl == ID_W'(i + 1));
    end
    // A fresh edge in the ack cycle keeps the line pending.
    pend_d = (pend_q & ~ack_clr) | edge_w;
    // eret clears first, then the ack sets.
    isv_d  = (isv_q & ~isv_clr) | ack_clr;
    // Arbitrate on what will be true after this edge, minus
    // same-cycle edges so latency stays fixed.
    pend_eff = pend_q & ~ack_clr;
    lvl_n    = ID_W'(hsb_id(MAX_IRQ'(isv_d)));
    pid      = ID_W'(hsb_id(MAX_IRQ'(pend_eff)));
    has      = pid > lvl_n;
    req_d    = int_en & has;
    id_d     = has ? pid : ID_W'(ID_NONE);
    vec_d    = '0;
    if (has) begin
      vec_d = VEC_BASE
            + ADDR_WIDTH'(pid - 1'b1) * VEC_STRIDE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      isv_q  <= '0;
      req_q  <= 1'b0;
      id_q   <= '0;
      vec_q  <= '0;
    end else begin
      pend_q <= pend_d;
      isv_q  <= isv_d;
      req_q  <= req_d;
      id_q   <= id_d;
      vec_q  <= vec_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_id     = id_q;
  assign irq_vec    = vec_q;
  assign irw        = pend_q;
  assign in_service = isv_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
// Inputs change 1 time unit after rising edges; outputs sampled there too.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  irq_raw = '0;
  logic        int_en = 1'b0;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [15:0] irq_vec;
  logic [2:0]  irw;
  logic [2:0]  in_service;

  int checks = 0;
  int errors = 0;

  irq_controller dut (
    .clk       (clk),
    .rst       (rst),
    .irq_raw   (irq_raw),
    .int_en    (int_en),
    .int_ack   (int_ack),
    .eret      (eret),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_vec   (irq_vec),
    .irw       (irw),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after edge k (first edge sampling the request).
  task automatic pulse_raw(input logic [2:0] m);
    irq_raw = m;
    tick(1);
    irq_raw = '0;
  endtask

  task automatic do_ack;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic do_eret;
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
  endtask

  task automatic test_reset;
    logic [24:0] obs;
    #2;
    obs = {irq_req, irq_id, irq_vec, irw, in_service};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_init: got %h exp 0", obs);
    end
    tick(2);
    rst = 1'b1;
    int_en = 1'b1;
    tick(1);
    pulse_raw(3'b010);
    tick(1);
    tick(1);
    checks++;
    if (irw !== 3'b010) begin
      errors++;
      $display("FAIL reset_pend_pre: got %b exp 010", irw);
    end
    rst = 1'b0;
    #1;
    obs = {irq_req, irq_id, irq_vec, irw, in_service};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h exp 0", obs);
    end
    tick(2);
    rst = 1'b1;
    tick(6);
    checks++;
    if ({irq_req, irw} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: got %b exp 0000",
               {irq_req, irw});
    end
  endtask

  task automatic test_single;
    pulse_raw(3'b001);
    tick(2);
    checks++;
    if ({irw, irq_req} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL single_k2: got %b exp 0010",
               {irw, irq_req});
    end
    tick(1);
    checks++;
    if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd1, 16'h0100}) begin
      errors++;
      $display("FAIL single_k3: got %b %0d %h exp 1 1 0100",
               irq_req, irq_id, irq_vec);
    end
    do_ack();
    checks++;
    if ({irw, in_service, irq_req} !== {3'b000, 3'b001, 1'b0}) begin
      errors++;
      $display("FAIL single_ack: got %b %b %b exp 000 001 0",
               irw, in_service, irq_req);
    end
    do_eret();
    checks++;
    if (in_service !== 3'b000) begin
      errors++;
      $display("FAIL single_eret: got %b exp 000", in_service);
    end
  endtask

  task automatic test_priority;
    pulse_raw(3'b101);
    tick(3);
    checks++;
    if ({irq_req, irq_id, irq_vec, irw}
        !== {1'b1, 2'd3, 16'h0180, 3'b101}) begin
      errors++;
      $display("FAIL prio_sel: got %b %0d %h %b exp 1 3 0180 101",
               irq_req, irq_id, irq_vec, irw);
    end
    do_ack();
    checks++;
    if ({irq_req, irq_id, in_service, irw}
        !== {1'b0, 2'd0, 3'b100, 3'b001}) begin
      errors++;
      $display("FAIL prio_ack: got %b %0d %b %b exp 0 0 100 001",
               irq_req, irq_id, in_service, irw);
    end
    do_eret();
    checks++;
    if ({irq_req, irq_id, irq_vec, in_service}
        !== {1'b1, 2'd1, 16'h0100, 3'b000}) begin
      errors++;
      $display("FAIL prio_eret: got %b %0d %h %b exp 1 1 0100 000",
               irq_req, irq_id, irq_vec, in_service);
    end
    do_ack();
    do_eret();
    checks++;
    if ({irq_req, in_service, irw} !== 7'b0) begin
      errors++;
      $display("FAIL prio_idle: got %b exp 0000000",
               {irq_req, in_service, irw});
    end
  endtask

  task automatic test_nesting;
    pulse_raw(3'b001);
    tick(3);
    checks++;
    if ({irq_req, irq_id} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL nest_l0: got %b %0d exp 1 1", irq_req, irq_id);
    end
    do_ack();
    checks++;
    if ({in_service, irq_req} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL nest_ack0: got %b %b exp 001 0",
               in_service, irq_req);
    end
    pulse_raw(3'b010);
    tick(3);
    checks++;
    if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd2, 16'h0140}) begin
      errors++;
      $display("FAIL nest_l1: got %b %0d %h exp 1 2 0140",
               irq_req, irq_id, irq_vec);
    end
    do_ack();
    checks++;
    if ({in_service, irq_req} !== {3'b011, 1'b0}) begin
      errors++;
      $display("FAIL nest_ack1: got %b %b exp 011 0",
               in_service, irq_req);
    end
    do_eret();
    checks++;
    if ({in_service, irq_req} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL nest_eret1: got %b %b exp 001 0",
               in_service, irq_req);
    end
    do_eret();
    checks++;
    if (in_service !== 3'b000) begin
      errors++;
      $display("FAIL nest_eret2: got %b exp 000", in_service);
    end
  endtask

  task automatic test_mask;
    int_en = 1'b0;
    pulse_raw(3'b100);
    tick(3);
    checks++;
    if ({irw, irq_req} !== {3'b100, 1'b0}) begin
      errors++;
      $display("FAIL mask_pend: got %b %b exp 100 0", irw, irq_req);
    end
    do_ack();
    checks++;
    if ({irw, in_service, irq_req} !== {3'b100, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL mask_ack_ign: got %b %b %b exp 100 000 0",
               irw, in_service, irq_req);
    end
    int_en = 1'b1;
    tick(1);
    checks++;
    if ({irq_req, irq_id} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL mask_unmask: got %b %0d exp 1 3",
               irq_req, irq_id);
    end
    do_ack();
    do_eret();
  endtask

  task automatic test_ack_edge_race;
    pulse_raw(3'b001);
    tick(3);
    checks++;
    if ({irq_req, irq_id} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL race_pres: got %b %0d exp 1 1", irq_req, irq_id);
    end
    pulse_raw(3'b001);
    tick(1);
    do_ack();
    checks++;
    if ({irw, in_service, irq_req} !== {3'b001, 3'b001, 1'b0}) begin
      errors++;
      $display("FAIL race_keep: got %b %b %b exp 001 001 0",
               irw, in_service, irq_req);
    end
    do_eret();
    checks++;
    if ({irq_req, irq_id, in_service} !== {1'b1, 2'd1, 3'b000}) begin
      errors++;
      $display("FAIL race_repres: got %b %0d %b exp 1 1 000",
               irq_req, irq_id, in_service);
    end
    do_ack();
    do_eret();
  endtask

  task automatic test_back_to_back;
    pulse_raw(3'b001);
    tick(3);
    do_ack();
    pulse_raw(3'b010);
    tick(3);
    int_ack = 1'b1;
    eret = 1'b1;
    tick(1);
    int_ack = 1'b0;
    eret = 1'b0;
    checks++;
    if ({in_service, irw, irq_req} !== {3'b010, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL b2b_ack_eret: got %b %b %b exp 010 000 0",
               in_service, irw, irq_req);
    end
    do_eret();
    checks++;
    if (in_service !== 3'b000) begin
      errors++;
      $display("FAIL b2b_eret: got %b exp 000", in_service);
    end
    do_eret();
    checks++;
    if ({in_service, irw, irq_req} !== 7'b0) begin
      errors++;
      $display("FAIL b2b_eret_noop: got %b exp 0000000",
               {in_service, irw, irq_req});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_mask();
    test_ack_edge_race();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
